// File: rtl/bulk_xfer_ctrl.sv
// Bulk-OUT sequencer: admits USB bytes into the read FIFO and drains it to the
// SD write engine in fixed-size blocks until the requested block count is done.
module bulk_xfer_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned BLOCK_SIZE  = 512,
    parameter int unsigned START_LEVEL = 32
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        xfer_start,
    input  logic [15:0] xfer_blocks,
    input  logic        abort,
    output logic        busy,
    output logic        xfer_done,
    output logic        xfer_err,
    input  logic        usb_valid,
    input  logic [7:0]  usb_data,
    output logic        usb_ready,
    output logic        fifo_wen,
    output logic [7:0]  fifo_wdata,
    output logic        fifo_ren,
    input  logic [7:0]  fifo_rdata,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    output logic        sd_start,
    output logic        sd_valid,
    output logic [7:0]  sd_data,
    input  logic        sd_ready,
    input  logic        sd_done
);

    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BYTE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int unsigned RX_W   = 25;
    localparam int unsigned BLK_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LVL,
        S_START,
        S_DATA,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [RX_W-1:0]    rx_left_q, rx_left_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0]   blocks_q, blocks_d;
    logic               err_q, err_d;
    logic               usb_side;
    logic               abort_take;

    // State and counter registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            rx_left_q  <= '0;
            occ_q      <= '0;
            byte_cnt_q <= '0;
            blk_cnt_q  <= '0;
            blocks_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_left_q  <= rx_left_d;
            occ_q      <= occ_d;
            byte_cnt_q <= byte_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            blocks_q   <= blocks_d;
            err_q      <= err_d;
        end
    end

    // Next-state, counters and handshake outputs
    always_comb begin
        state_d    = state_q;
        rx_left_d  = rx_left_q;
        occ_d      = occ_q;
        byte_cnt_d = byte_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        blocks_d   = blocks_q;
        err_d      = 1'b0;
        xfer_done  = 1'b0;
        sd_start   = 1'b0;
        sd_valid   = 1'b0;
        sd_data    = 8'h00;
        fifo_ren   = 1'b0;

        abort_take = abort && (state_q != S_IDLE);
        // An abort cycle performs no handshakes so nothing is half-transferred.
        usb_side   = (state_q != S_IDLE) && (state_q != S_DONE) && !abort;
        usb_ready  = usb_side && !fifo_full && (rx_left_q != '0);
        fifo_wen   = usb_ready && usb_valid;
        fifo_wdata = fifo_wen ? usb_data : 8'h00;
        if (fifo_wen) begin
            rx_left_d = rx_left_q - RX_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (xfer_start) begin
                    blocks_d   = xfer_blocks;
                    rx_left_d  = RX_W'(xfer_blocks) * RX_W'(BLOCK_SIZE);
                    blk_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = (xfer_blocks == '0) ? S_DONE : S_WAIT_LVL;
                end
            end
            S_WAIT_LVL: begin
                if ((occ_q >= OCC_W'(START_LEVEL)) || (rx_left_q == '0)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                sd_start   = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                sd_valid = !fifo_empty;
                sd_data  = sd_valid ? fifo_rdata : 8'h00;
                fifo_ren = sd_valid && sd_ready;
                if (fifo_ren) begin
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    if (byte_cnt_q == BYTE_W'(BLOCK_SIZE - 1)) begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (sd_done) begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                    state_d   = ((blk_cnt_q + BLK_W'(1)) == blocks_q) ? S_DONE : S_WAIT_LVL;
                end
            end
            S_DONE: begin
                xfer_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_take) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            rx_left_d  = '0;
            occ_d      = '0;
            byte_cnt_d = '0;
            blk_cnt_d  = '0;
            blocks_d   = '0;
            xfer_done  = 1'b0;
            sd_start   = 1'b0;
            sd_valid   = 1'b0;
            sd_data    = 8'h00;
            fifo_ren   = 1'b0;
        end else if (fifo_wen && !fifo_ren && (occ_q < OCC_W'(FIFO_DEPTH))) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (fifo_ren && !fifo_wen && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign xfer_err = err_q;

endmodule

// File: tb/tb_bulk_xfer_ctrl.sv
// Self-checking bench for bulk_xfer_ctrl with a behavioural FWFT FIFO and a
// byte scoreboard between the USB side and the SD side.
module tb_bulk_xfer_ctrl;

    localparam int BS    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        xfer_start = 1'b0;
    logic [15:0] xfer_blocks = '0;
    logic        abort = 1'b0;
    logic        busy, xfer_done, xfer_err;
    logic        usb_valid = 1'b0;
    logic [7:0]  usb_data = '0;
    logic        usb_ready, fifo_wen, fifo_ren;
    logic [7:0]  fifo_wdata, fifo_rdata;
    logic        fifo_empty, fifo_full;
    logic        sd_start, sd_valid;
    logic [7:0]  sd_data;
    logic        sd_ready = 1'b0;
    logic        sd_done = 1'b0;

    logic        tb_flush = 1'b1;
    logic [7:0]  fmem [DEPTH];
    logic [1:0]  fwp = '0;
    logic [1:0]  frp = '0;
    logic [2:0]  fcnt = '0;

    logic [7:0]  sb [$];
    int n_pass = 0, n_total = 0;
    int nacc, npops, nstart, nsdone, nxdone, nerr, nrdy, nlate, nviol, nboth;
    int ndone_issued, done_wait, exp_bytes, data_base;
    int cyc = 0, start_cyc, sdone_cyc, xdone_cyc, sd_at_xdone;

    bulk_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .BLOCK_SIZE(BS), .START_LEVEL(4)) dut (
        .clk(clk), .n_rst(n_rst), .xfer_start(xfer_start), .xfer_blocks(xfer_blocks),
        .abort(abort), .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
        .usb_valid(usb_valid), .usb_data(usb_data), .usb_ready(usb_ready),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_ren(fifo_ren),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .sd_start(sd_start), .sd_valid(sd_valid), .sd_data(sd_data),
        .sd_ready(sd_ready), .sd_done(sd_done)
    );

    always #5 clk = ~clk;

    // Behavioural first-word-fall-through FIFO attached to the controller
    always @(posedge clk) begin
        if (tb_flush) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
        end else begin
            if (fifo_wen && !fifo_full) begin
                fmem[fwp] <= fifo_wdata;
                fwp       <= fwp + 2'd1;
            end
            if (fifo_ren && !fifo_empty) frp <= frp + 2'd1;
            fcnt <= fcnt + 3'(fifo_wen && !fifo_full) - 3'(fifo_ren && !fifo_empty);
        end
    end
    assign fifo_empty = (fcnt == 3'd0);
    assign fifo_full  = (fcnt == 3'd4);
    assign fifo_rdata = fmem[frp];

    task automatic clear_stats();
        tb_flush = 1'b1;
        @(posedge clk);
        #1 tb_flush = 1'b0;
        sb.delete();
        nacc = 0; npops = 0; nstart = 0; nsdone = 0; nxdone = 0; nerr = 0;
        nrdy = 0; nlate = 0; nviol = 0; nboth = 0; ndone_issued = 0; done_wait = 0;
        start_cyc = -1; sdone_cyc = -1; xdone_cyc = -1; sd_at_xdone = -1;
    endtask

    // Drives USB bytes and the SD engine; scoreboards every popped byte.
    // status: 0 done/err, 1 pop target reached, 2 cycle target reached, 3 timeout
    task automatic run_xfer(input bit do_start, input int blocks, input int vpct,
                            input int rpct, input int stop_pops, input int stop_cyc,
                            input int budget, output int status);
        logic [7:0] exp;
        status = 3;
        if (do_start) exp_bytes = blocks * BS;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            xfer_start  = do_start && (n == 0);
            xfer_blocks = 16'(blocks);
            usb_valid   = (nacc < exp_bytes) && ($urandom_range(99) < vpct);
            usb_data    = 8'(data_base + nacc);
            sd_ready    = ($urandom_range(99) < rpct);
            sd_done     = 1'b0;
            if (npops / BS > ndone_issued) begin
                done_wait++;
                if (done_wait >= 2) begin
                    sd_done = 1'b1;
                    ndone_issued++;
                    done_wait = 0;
                end
            end
            @(negedge clk);
            cyc++;
            if (xfer_start && !busy) start_cyc = cyc;
            if (usb_ready) nrdy++;
            if (usb_ready && nacc >= exp_bytes) nlate++;
            if (fifo_wen && fifo_ren) nboth++;
            if (fifo_wen) begin
                if (fifo_full) nviol++;
                sb.push_back(usb_data);
                nacc++;
            end
            if (fifo_ren) begin
                if (fifo_empty || !sd_valid) nviol++;
                npops++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sd_data: popped 0x%02h, scoreboard empty", sd_data);
                end else begin
                    exp = sb.pop_front();
                    if (sd_data !== exp)
                        $display("FAIL sd_data[%0d]: got 0x%02h, expected 0x%02h", npops - 1, sd_data, exp);
                    else n_pass++;
                end
            end
            if (sd_start) nstart++;
            if (sd_done) begin nsdone++; sdone_cyc = cyc; end
            if (xfer_err) nerr++;
            if (xfer_done) begin nxdone++; xdone_cyc = cyc; sd_at_xdone = nsdone; end
            if (xfer_done || xfer_err) begin status = 0; break; end
            if (stop_pops > 0 && npops >= stop_pops) begin status = 1; break; end
            if (stop_cyc > 0 && n + 1 >= stop_cyc) begin status = 2; break; end
        end
        usb_valid  = 1'b0;
        xfer_start = 1'b0;
        sd_done    = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        #1 n_rst = 1'b0;
        #2;
        outs = {busy, xfer_done, xfer_err, usb_ready, fifo_wen, fifo_wdata, fifo_ren,
                sd_start, sd_valid, sd_data};
        n_total++;
        if (outs !== 24'h0) $display("FAIL reset_outputs: got 0x%06h, expected 0x000000", outs);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        clear_stats();
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || usb_ready !== 1'b0)
            $display("FAIL reset_idle: busy=%b usb_ready=%b, expected 0 0", busy, usb_ready);
        else n_pass++;
    endtask

    task automatic test_single_block();
        int st;
        clear_stats();
        data_base = 0;
        run_xfer(1, 1, 100, 100, 0, 0, 200, st);
        n_total++; if (st !== 0) $display("FAIL t1_status: got %0d, expected 0", st); else n_pass++;
        n_total++; if (nstart !== 1) $display("FAIL t1_sd_start: got %0d, expected 1", nstart); else n_pass++;
        n_total++; if (npops !== 8) $display("FAIL t1_pops: got %0d, expected 8", npops); else n_pass++;
        n_total++; if (nxdone !== 1) $display("FAIL t1_xfer_done: got %0d, expected 1", nxdone); else n_pass++;
        n_total++;
        if (xdone_cyc !== sdone_cyc + 1)
            $display("FAIL t1_done_latency: got cycle %0d, expected %0d", xdone_cyc, sdone_cyc + 1);
        else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL t1_busy_fall: got %b, expected 0", busy); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL t1_residue: got %0d, expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_multi_block_gaps();
        int st;
        clear_stats();
        data_base = 8'h40;
        run_xfer(1, 3, 60, 60, 0, 0, 2000, st);
        n_total++; if (st !== 0) $display("FAIL t2_status: got %0d, expected 0", st); else n_pass++;
        n_total++; if (nstart !== 3) $display("FAIL t2_sd_start: got %0d, expected 3", nstart); else n_pass++;
        n_total++; if (npops !== 24) $display("FAIL t2_pops: got %0d, expected 24", npops); else n_pass++;
        n_total++; if (nviol !== 0) $display("FAIL t2_handshake: got %0d violations, expected 0", nviol); else n_pass++;
        n_total++; if (nxdone !== 1) $display("FAIL t2_xfer_done: got %0d, expected 1", nxdone); else n_pass++;
        n_total++;
        if (sd_at_xdone !== 3) $display("FAIL t2_done_order: got %0d sd_done before xfer_done, expected 3", sd_at_xdone);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        int st;
        clear_stats();
        data_base = 8'h80;
        run_xfer(1, 1, 100, 0, 0, 20, 100, st);
        n_total++; if (st !== 2) $display("FAIL t3_stall_status: got %0d, expected 2", st); else n_pass++;
        n_total++;
        if (fifo_full !== 1'b1 || usb_ready !== 1'b0)
            $display("FAIL t3_backpressure: fifo_full=%b usb_ready=%b, expected 1 0", fifo_full, usb_ready);
        else n_pass++;
        n_total++; if (nacc !== 4) $display("FAIL t3_occupancy: got %0d writes, expected 4", nacc); else n_pass++;
        run_xfer(0, 1, 100, 100, 0, 0, 300, st);
        n_total++; if (st !== 0) $display("FAIL t3_status: got %0d, expected 0", st); else n_pass++;
        n_total++; if (npops !== 8) $display("FAIL t3_pops: got %0d, expected 8", npops); else n_pass++;
        n_total++; if (nviol !== 0) $display("FAIL t3_handshake: got %0d violations, expected 0", nviol); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st;
        clear_stats();
        data_base = 8'hC0;
        run_xfer(1, 1, 100, 100, 0, 0, 200, st);
        n_total++; if (st !== 0) $display("FAIL t4_status: got %0d, expected 0", st); else n_pass++;
        n_total++; if (nboth !== 4) $display("FAIL t4_simultaneous: got %0d, expected 4", nboth); else n_pass++;
        n_total++; if (nacc !== 8) $display("FAIL t4_writes: got %0d, expected 8", nacc); else n_pass++;
        n_total++; if (nlate !== 0) $display("FAIL t4_ready_after_last: got %0d, expected 0", nlate); else n_pass++;
    endtask

    task automatic test_zero_blocks();
        int st;
        clear_stats();
        run_xfer(1, 0, 100, 100, 0, 0, 20, st);
        n_total++; if (st !== 0) $display("FAIL t5_status: got %0d, expected 0", st); else n_pass++;
        n_total++;
        if (xdone_cyc !== start_cyc + 1)
            $display("FAIL t5_done_latency: got cycle %0d, expected %0d", xdone_cyc, start_cyc + 1);
        else n_pass++;
        n_total++; if (nstart !== 0) $display("FAIL t5_sd_start: got %0d, expected 0", nstart); else n_pass++;
        n_total++; if (nrdy !== 0) $display("FAIL t5_usb_ready: got %0d, expected 0", nrdy); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL t5_busy: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_abort_reset();
        int st;
        logic [23:0] outs;
        clear_stats();
        data_base = 8'h20;
        run_xfer(1, 2, 100, 100, 3, 0, 200, st);
        n_total++; if (st !== 1) $display("FAIL t6_reach_data: got %0d, expected 1", st); else n_pass++;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_total++;
        if (xfer_err !== 1'b1 || busy !== 1'b0 || xfer_done !== 1'b0)
            $display("FAIL t6_abort: err=%b busy=%b done=%b, expected 1 0 0", xfer_err, busy, xfer_done);
        else n_pass++;
        @(negedge clk);
        n_total++; if (xfer_err !== 1'b0) $display("FAIL t6_err_pulse: got %b, expected 0", xfer_err); else n_pass++;

        clear_stats();
        run_xfer(1, 1, 100, 100, 2, 0, 200, st);
        n_total++; if (st !== 1) $display("FAIL t6_reach_data2: got %0d, expected 1", st); else n_pass++;
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        outs = {busy, xfer_done, xfer_err, usb_ready, fifo_wen, fifo_wdata, fifo_ren,
                sd_start, sd_valid, sd_data};
        n_total++;
        if (outs !== 24'h0) $display("FAIL t6_async_reset: got 0x%06h, expected 0x000000", outs);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;

        clear_stats();
        data_base = 8'h60;
        run_xfer(1, 1, 100, 100, 0, 0, 300, st);
        n_total++; if (st !== 0) $display("FAIL t6_restart: got %0d, expected 0", st); else n_pass++;
        n_total++;
        if (nxdone !== 1 || npops !== 8 || nerr !== 0)
            $display("FAIL t6_restart_result: done=%0d pops=%0d err=%0d, expected 1 8 0", nxdone, npops, nerr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block_gaps();
        test_fifo_full();
        test_back_to_back();
        test_zero_blocks();
        test_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
